// File: rtl/inst_queue.sv
// inst_queue: circular-buffer instruction queue between fetch and dispatch.
// Holds {pc, inst} packets plus a prediction bit, presents the head entry
// combinationally, and tags each dispatched instruction with a 16-bit age
// that survives flushes so ages stay monotonic across mispredicts.
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  input  logic [WIDTH-1:0] enq_packet,
  input  logic             enq_pred,
  output logic             full,
  input  logic             deq_ready,
  output logic             valid_inst,
  output logic [WIDTH-1:0] queue_packet,
  output logic             branch_pred,
  output logic [15:0]      age,
  input  logic             flush
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      age_q, age_d;
  logic [WIDTH-1:0] pkt_mem_q [DEPTH];
  logic [DEPTH-1:0] pred_mem_q;
  logic             enq_fire_s;
  logic             deq_fire_s;

  // Status comes from the registered count only, so a same-cycle pop never
  // frees a slot for a same-cycle push.
  assign full       = (count_q == DEPTH_C);
  assign valid_inst = (count_q != {CW{1'b0}});

  // Flush wins over both ports; accepted transfers are squashed with it.
  assign enq_fire_s = enq_valid && !full && !flush;
  assign deq_fire_s = deq_ready && valid_inst && !flush;

  // Head-entry read port; contents are meaningless while valid_inst is low.
  assign queue_packet = pkt_mem_q[head_q];
  assign branch_pred  = pred_mem_q[head_q];
  assign age          = age_q;

  // Next-state for pointers, occupancy and the dispatch age counter.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    age_d   = age_q;
    if (flush) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (enq_fire_s) begin
        tail_d = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (deq_fire_s) begin
        head_d = head_q + PW'(1);
        age_d  = age_q + 16'd1;
      end else begin
        head_d = head_q;
        age_d  = age_q;
      end
      case ({enq_fire_s, deq_fire_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset clears occupancy and age immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      age_q   <= 16'h0000;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      age_q   <= age_d;
    end
  end

  // Packet storage is written at the tail and never needs clearing.
  always_ff @(posedge clk) begin
    if (enq_fire_s) begin
      pkt_mem_q[tail_q]  <= enq_packet;
      pred_mem_q[tail_q] <= enq_pred;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: a scoreboard queue of expected
// {pred, packet} entries plus a model age counter, compared at dequeue time.
module tb_inst_queue;

  localparam int DEPTH = 16;
  localparam int WIDTH = 64;

  logic             clk;
  logic             rst;
  logic             enq_valid;
  logic [WIDTH-1:0] enq_packet;
  logic             enq_pred;
  logic             full;
  logic             deq_ready;
  logic             valid_inst;
  logic [WIDTH-1:0] queue_packet;
  logic             branch_pred;
  logic [15:0]      age;
  logic             flush;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [64:0] sb [$];
  logic [15:0] model_age = 16'h0000;

  inst_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_packet(enq_packet),
    .enq_pred(enq_pred), .full(full), .deq_ready(deq_ready),
    .valid_inst(valid_inst), .queue_packet(queue_packet),
    .branch_pred(branch_pred), .age(age), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, update the scoreboard model at the edge, settle 1ns after.
  task automatic drive_cycle(input logic ev, input logic [63:0] pkt, input logic pr,
                             input logic dr, input logic fl);
    logic acc_e, acc_d;
    enq_valid  = ev;
    enq_packet = pkt;
    enq_pred   = pr;
    deq_ready  = dr;
    flush      = fl;
    acc_e = ev && (sb.size() < DEPTH);
    acc_d = dr && (sb.size() > 0);
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (acc_d) begin
        void'(sb.pop_front());
        model_age = model_age + 16'd1;
      end
      if (acc_e) sb.push_back({pr, pkt});
    end
    #1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
  endtask

  function automatic logic [63:0] mk_pkt(input logic [31:0] pc);
    return {pc, $urandom()};
  endfunction

  task automatic test_reset();
    rst = 1'b0; enq_valid = 1'b0; enq_packet = '0; enq_pred = 1'b0;
    deq_ready = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (valid_inst !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_inst); end
    n_checks++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++;
    if (age !== 16'h0000) begin n_fail++; $display("FAIL reset_age got %h want 0000", age); end
    rst = 1'b1;
    sb.delete();
    model_age = 16'h0000;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] pc;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      if (i == 0) begin
        enq_valid = 1'b1;
        n_checks++;
        if (valid_inst !== 1'b0) begin n_fail++; $display("FAIL no_bypass got %b want 0", valid_inst); end
      end
      drive_cycle(1'b1, mk_pkt(pc), i[0], 1'b0, 1'b0);
      if (i == 0) begin
        n_checks++;
        if (valid_inst !== 1'b1) begin n_fail++; $display("FAIL first_visible got %b want 1", valid_inst); end
      end
    end
    n_checks++;
    if (queue_packet[63:32] !== 32'h1000) begin n_fail++; $display("FAIL basic_head_pc got %h want 00001000", queue_packet[63:32]); end
    n_checks++;
    if (dut.count_q !== 5'd4) begin n_fail++; $display("FAIL basic_count got %0d want 4", dut.count_q); end
    for (int i = 0; i < 4; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      n_checks++;
      if (queue_packet !== sb[0][63:0] || queue_packet[63:32] !== pc || branch_pred !== sb[0][64])
        begin n_fail++; $display("FAIL basic_order got %h/%b want %h/%b", queue_packet, branch_pred, sb[0][63:0], sb[0][64]); end
      n_checks++;
      if (age !== 16'(i)) begin n_fail++; $display("FAIL basic_age got %0d want %0d", age, i); end
      drive_cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (valid_inst !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %b want 0", valid_inst); end
    // dequeue with nothing valid must be ignored
    drive_cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (age !== 16'd4 || dut.count_q !== 5'd0) begin n_fail++; $display("FAIL deq_empty age %0d count %0d want 4 0", age, dut.count_q); end
  endtask

  task automatic test_flush();
    while (model_age != 16'd7) begin
      drive_cycle(1'b1, mk_pkt(32'h2000), 1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, mk_pkt(32'h3000 + 32'(4 * i)), 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (age !== 16'd7 || dut.count_q !== 5'd5) begin n_fail++; $display("FAIL flush_pre age %0d count %0d want 7 5", age, dut.count_q); end
    drive_cycle(1'b1, mk_pkt(32'h4000), 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (valid_inst !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", valid_inst); end
    n_checks++;
    if (dut.count_q !== 5'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", dut.count_q); end
    n_checks++;
    if (age !== 16'd7) begin n_fail++; $display("FAIL flush_age got %0d want 7", age); end
    drive_cycle(1'b1, mk_pkt(32'h5000), 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (queue_packet !== sb[0][63:0] || queue_packet[63:32] !== 32'h5000)
      begin n_fail++; $display("FAIL flush_refill got %h want %h", queue_packet, sb[0][63:0]); end
    drive_cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, mk_pkt(32'h6000 + 32'(4 * i)), i[1], 1'b0, 1'b0);
    n_checks++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL full_set got %b want 1", full); end
    drive_cycle(1'b1, mk_pkt(32'hDEAD0000), 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (full !== 1'b1 || dut.count_q !== 5'd16) begin n_fail++; $display("FAIL full_drop full %b count %0d want 1 16", full, dut.count_q); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (queue_packet !== sb[0][63:0] || queue_packet[63:32] !== 32'h6000 + 32'(4 * i) || branch_pred !== sb[0][64] || age !== model_age)
        begin n_fail++; $display("FAIL full_order got %h/%b/%h want %h/%b/%h", queue_packet, branch_pred, age, sb[0][63:0], sb[0][64], model_age); end
      drive_cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (valid_inst !== 1'b0) begin n_fail++; $display("FAIL full_drained got %b want 0", valid_inst); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, mk_pkt(32'h7000 + 32'(4 * i)), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (queue_packet !== sb[0][63:0]) begin n_fail++; $display("FAIL simul_head got %h want %h", queue_packet, sb[0][63:0]); end
    drive_cycle(1'b1, mk_pkt(32'h7FFF), 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (dut.count_q !== 5'd15) begin n_fail++; $display("FAIL simul_count got %0d want 15", dut.count_q); end
    n_checks++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL simul_full got %b want 0", full); end
    while (sb.size() > 0) begin
      n_checks++;
      if (queue_packet !== sb[0][63:0]) begin n_fail++; $display("FAIL simul_order got %h want %h", queue_packet, sb[0][63:0]); end
      drive_cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic seen_wrap = 1'b0;
    drive_cycle(1'b1, mk_pkt(32'h8000), 1'b0, 1'b0, 1'b0);
    while (model_age != 16'hFFFE) drive_cycle(1'b1, mk_pkt(32'h8000), 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (age !== 16'hFFFE) begin n_fail++; $display("FAIL preset_age got %h want fffe", age); end
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if (queue_packet !== sb[0][63:0] || branch_pred !== sb[0][64] || age !== model_age)
        begin n_fail++; $display("FAIL b2b_order got %h/%b/%h want %h/%b/%h", queue_packet, branch_pred, age, sb[0][63:0], sb[0][64], model_age); end
      if (age == 16'h0000) seen_wrap = 1'b1;
      drive_cycle(1'b1, mk_pkt(32'h9000 + 32'(4 * i)), i[0], 1'b1, 1'b0);
    end
    n_checks++;
    if (age !== 16'd38 || seen_wrap !== 1'b1) begin n_fail++; $display("FAIL age_wrap got %h wrap %b want 0026 1", age, seen_wrap); end
    while (sb.size() > 0) begin
      n_checks++;
      if (queue_packet !== sb[0][63:0]) begin n_fail++; $display("FAIL b2b_tail got %h want %h", queue_packet, sb[0][63:0]); end
      drive_cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, mk_pkt(32'hA000 + 32'(4 * i)), 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (valid_inst !== 1'b1 || age === 16'h0000) begin n_fail++; $display("FAIL areset_pre valid %b age %h want 1 nonzero", valid_inst, age); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (valid_inst !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", valid_inst); end
    n_checks++;
    if (age !== 16'h0000) begin n_fail++; $display("FAIL areset_age got %h want 0000", age); end
    sb.delete();
    model_age = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    drive_cycle(1'b1, mk_pkt(32'hB000), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (valid_inst !== 1'b1 || queue_packet !== sb[0][63:0] || dut.count_q !== 5'd1)
      begin n_fail++; $display("FAIL post_reset got %b/%h/%0d want 1/%h/1", valid_inst, queue_packet, dut.count_q, sb[0][63:0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_full();
    test_full_simul();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two, >= 4).
REQ-002 SHALL have parameter WIDTH, default 64, packet width {pc[31:0], inst[31:0]}.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enq_valid  input  1  fetch offers a packet this cycle.
REQ-006 SHALL have port enq_packet  input  WIDTH  {pc, inst} from fetch.
REQ-007 SHALL have port enq_pred  input  1  branch prediction bit for the packet.
REQ-008 SHALL have port full  output  1  queue holds DEPTH entries.
REQ-009 SHALL have port deq_ready  input  1  dispatch consumes the head this cycle (ROB/RS/LSQ have space).
REQ-010 SHALL have port valid_inst  output  1  head entry valid, i.e. queue not empty.
REQ-011 SHALL have port queue_packet  output  WIDTH  head packet.
REQ-012 SHALL have port branch_pred  output  1  prediction bit of head entry.
REQ-013 SHALL have port age  output  16  sequence number of head instruction, for the load/store queue.
REQ-014 SHALL have port flush  input  1  branch mispredict; discard all entries.

Function
REQ-015 Storage SHALL be a circular buffer: head pointer, tail pointer, count of width clog2(DEPTH)+1.
REQ-016 Enqueue SHALL occur iff enq_valid && !full; packet and pred written at tail, tail += 1 mod DEPTH.
REQ-017 Enqueue with full=1 SHALL be dropped with no state change; fetch holds the packet.
REQ-018 full SHALL derive from registered count only; a same-cycle dequeue SHALL NOT make room for a same-cycle enqueue.
REQ-019 Dequeue SHALL occur iff deq_ready && valid_inst; head += 1 mod DEPTH.
REQ-020 deq_ready with valid_inst=0 SHALL be ignored.
REQ-021 Simultaneous accepted enqueue and dequeue SHALL leave count unchanged.
REQ-022 Count SHALL never exceed DEPTH nor drop below 0.
REQ-023 valid_inst SHALL equal (count != 0); queue_packet, branch_pred and age SHALL be combinational reads of the head entry.
REQ-024 Latency: a packet accepted at edge N SHALL appear at the outputs after edge N when the queue was empty (no same-cycle bypass).
REQ-025 With valid_inst=0, queue_packet and branch_pred SHALL be don't-care; decode qualifies on valid_inst.
REQ-026 Order SHALL be strict FIFO across pointer wrap-around.
REQ-027 age SHALL be a 16-bit counter incremented by 1 on each dequeue, wrapping 0xFFFF -> 0x0000.
REQ-028 flush SHALL take priority: head, tail, count -> 0 at the edge; same-cycle enqueue and dequeue SHALL be discarded.
REQ-029 flush SHALL NOT reset age, so ages stay monotonic across mispredicts.
REQ-030 valid_inst SHALL be 0 in the cycle after a flush edge.

Reset
REQ-031 rst=0 SHALL immediately clear head, tail, count and age to 0, giving full=0, valid_inst=0, age=0x0000.
REQ-032 Reset asserted mid-operation SHALL discard all entries; storage contents need not be cleared.
REQ-033 The first accepted enqueue after rst deasserts SHALL behave as on an empty queue.

Verification
REQ-034 Enqueue pc=0x1000..0x100C (4 packets), deq_ready=0 -> valid_inst=1, queue_packet[63:32]=0x1000, count=4; then dequeue each in turn -> pcs 0x1000, 0x1004, 0x1008, 0x100C in order, age 0,1,2,3.
REQ-035 Fill 16 entries -> full=1; a 17th enq_valid -> dropped; dequeue all -> 16 packets in order, valid_inst=0 afterwards.
REQ-036 Full queue with enq_valid=1 and deq_ready=1 in the same cycle -> dequeue only, count 16->15, full=0 next cycle.
REQ-037 Push and pop continuously for 40 packets (wrap twice) -> output order matches input, age wraps correctly from a preset 0xFFFE.
REQ-038 5 entries with age=7, then flush=1 together with enq_valid=1 and deq_ready=1 -> next cycle valid_inst=0, count=0, age=7.
REQ-039 Assert rst=0 asynchronously between edges with 3 entries -> valid_inst=0 and age=0 immediately, without waiting for a clock edge.
